// File: rtl/lsu_pkg.sv
// Shared types and defaults for the load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B   = 2'b00,
        SZ_H   = 2'b01,
        SZ_W   = 2'b10,
        SZ_RSV = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_e;

    localparam int unsigned DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store replication, byte enables, misalignment check,
// and load extract with sign/zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  st_off,
    input  logic [1:0]  st_size,
    input  logic [31:0] st_data,
    output logic [31:0] st_wdata,
    output logic [3:0]  st_be,
    output logic        misaligned,
    input  logic [1:0]  ld_off,
    input  logic [1:0]  ld_size,
    input  logic        ld_unsigned,
    input  logic [31:0] rdata,
    output logic [31:0] ld_data
);

    logic [31:0] shifted;

    assign shifted = rdata >> {ld_off, 3'b000};

    // Store side: replicate data across lanes, derive enables and alignment.
    always_comb begin
        st_wdata   = st_data;
        st_be      = '0;
        misaligned = 1'b0;
        case (size_e'(st_size))
            SZ_B: begin
                st_wdata = {4{st_data[7:0]}};
                st_be    = 4'b0001 << st_off;
            end
            SZ_H: begin
                st_wdata   = {2{st_data[15:0]}};
                st_be      = 4'b0011 << st_off;
                misaligned = st_off[0];
            end
            SZ_W: begin
                st_be      = 4'b1111;
                misaligned = (st_off != 2'b00);
            end
            default: misaligned = 1'b1;
        endcase
    end

    // Load side: pick the addressed lanes and extend to 32 bits.
    always_comb begin
        ld_data = shifted;
        case (size_e'(ld_size))
            SZ_B:    ld_data = {{24{~ld_unsigned & shifted[7]}}, shifted[7:0]};
            SZ_H:    ld_data = {{16{~ld_unsigned & shifted[15]}}, shifted[15:0]};
            default: ld_data = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one access at a time, drives a simple req/ack
// memory port, aborts after TIMEOUT_CYCLES busy cycles without ack.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] addr,
    input  logic [31:0] mem_write,
    input  logic [1:0]  size,
    input  logic        ld_unsigned,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] load_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic [1:0]    off_q;
    logic [1:0]    size_q;
    logic          uns_q;
    logic          we_q;
    logic [3:0]    be_q;
    logic [31:0]   maddr_q;
    logic [31:0]   wdata_q;
    logic          err_q;
    logic [31:0]   load_q;

    logic          accept;
    logic          timeout;
    logic [31:0]   st_wdata;
    logic [3:0]    st_be;
    logic          st_misaligned;
    logic [31:0]   ld_ext;

    // Store steering uses live request inputs; load extract uses latched ones.
    lsu_align u_align (
        .st_off      (addr[1:0]),
        .st_size     (size),
        .st_data     (mem_write),
        .st_wdata    (st_wdata),
        .st_be       (st_be),
        .misaligned  (st_misaligned),
        .ld_off      (off_q),
        .ld_size     (size_q),
        .ld_unsigned (uns_q),
        .rdata       (mem_rdata),
        .ld_data     (ld_ext)
    );

    // Next-state logic; an ack on the final busy cycle beats the timeout.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        timeout = 1'b0;
        case (state_q)
            IDLE: begin
                if (rd_en || wr_en) begin
                    accept  = 1'b1;
                    state_d = st_misaligned ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    state_d = DONE;
                end else if (cnt_q == LAST) begin
                    timeout = 1'b1;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, request latch, busy counter and load result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            off_q   <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            we_q    <= 1'b0;
            be_q    <= '0;
            maddr_q <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            load_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                off_q   <= addr[1:0];
                size_q  <= size;
                uns_q   <= ld_unsigned;
                we_q    <= wr_en;
                be_q    <= st_be;
                maddr_q <= {addr[31:2], 2'b00};
                wdata_q <= st_wdata;
                err_q   <= st_misaligned;
                cnt_q   <= '0;
            end
            if (state_q == BUSY) begin
                cnt_q <= cnt_q + CW'(1);
                if (mem_ack) begin
                    err_q <= 1'b0;
                    if (!we_q) begin
                        load_q <= ld_ext;
                    end
                end else if (timeout) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign err       = done & err_q;
    assign mem_req   = (state_q == BUSY);
    assign mem_we    = mem_req & we_q;
    assign mem_be    = mem_req ? be_q : '0;
    assign mem_addr  = maddr_q;
    assign mem_wdata = wdata_q;
    assign load_data = load_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, hand-written
// multi-cycle sequences, and randomized accesses against a reference model.
module tb_load_store_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst, rd_en, wr_en, ld_unsigned, mem_ack;
    logic [31:0] addr, mem_write, mem_rdata;
    logic [1:0]  size;
    logic        busy, done, err, mem_req, mem_we;
    logic [31:0] load_data, mem_addr, mem_wdata;
    logic [3:0]  mem_be;

    int n_checks = 0;
    int n_fail   = 0;

    // Observations gathered by run_access.
    int          obs_nreq, obs_lat;
    logic        obs_done, obs_err, obs_stable, obs_we, obs_req_done;
    logic [31:0] obs_load, obs_addr, obs_wdata;
    logic [3:0]  obs_be, obs_be_done;

    logic [31:0] ld_model;

    typedef struct {
        logic        rd, wr;
        logic [31:0] a;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] wd, rdat;
        int          dly;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic        e_we;
        logic [31:0] e_load;
        logic        e_err;
        int          e_lat, e_nreq;
    } vec_t;

    vec_t vecs[12];

    load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .addr(addr),
        .mem_write(mem_write), .size(size), .ld_unsigned(ld_unsigned),
        .busy(busy), .done(done), .err(err), .load_data(load_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference load: shift by byte offset, truncate, extend.
    function automatic logic [31:0] ref_load(logic [31:0] rd, logic [1:0] off,
                                             logic [1:0] sz, logic uns);
        int unsigned v;
        v = rd / (32'd1 << (8 * int'(off)));
        if (sz == 2'd0) begin
            v = v % 256;
            if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            v = v % 65536;
            if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
        end
        return v;
    endfunction

    function automatic logic [3:0] ref_be(logic [1:0] off, logic [1:0] sz);
        if (sz == 2'd0) return 4'(1 * (2 ** int'(off)));
        if (sz == 2'd1) return 4'(3 * (2 ** int'(off)));
        return 4'hF;
    endfunction

    function automatic logic [31:0] ref_wdata(logic [31:0] d, logic [1:0] sz);
        if (sz == 2'd0) return (d % 256) * 32'h0101_0101;
        if (sz == 2'd1) return (d % 65536) * 32'h0001_0001;
        return d;
    endfunction

    // Launch one access, scramble inputs while it is in flight, answer with
    // mem_ack after ack_dly busy cycles, and record what the DUT did.
    task automatic run_access(input logic rd, input logic wr, input logic [31:0] a,
                              input logic [1:0] sz, input logic uns, input logic [31:0] wd,
                              input logic [31:0] rdat, input int ack_dly, input logic poke);
        int  breq = 0;
        logic seen = 1'b0;
        @(negedge clk);
        rd_en = rd; wr_en = wr; addr = a; size = sz; ld_unsigned = uns;
        mem_write = wd; mem_ack = 1'b0;
        obs_done = 1'b0; obs_lat = 0; obs_stable = 1'b1; obs_err = 1'b0;
        obs_addr = '0; obs_be = '0; obs_wdata = '0; obs_we = 1'b0;
        obs_load = '0; obs_be_done = '0; obs_req_done = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (done) begin
                obs_done = 1'b1; obs_lat = k; obs_err = err; obs_load = load_data;
                obs_be_done = mem_be; obs_req_done = mem_req;
                break;
            end
            mem_ack = 1'b0;
            mem_rdata = $urandom;
            if (mem_req) begin
                rd_en = 1'($urandom_range(0, 1)); wr_en = 1'($urandom_range(0, 1));
                addr = $urandom; mem_write = $urandom;
                size = 2'($urandom_range(0, 3)); ld_unsigned = 1'($urandom_range(0, 1));
                if (!seen) begin
                    seen = 1'b1;
                    obs_addr = mem_addr; obs_be = mem_be; obs_wdata = mem_wdata; obs_we = mem_we;
                end else if (mem_addr !== obs_addr || mem_be !== obs_be ||
                             mem_wdata !== obs_wdata || mem_we !== obs_we) begin
                    obs_stable = 1'b0;
                end
                if (breq == ack_dly) begin
                    mem_ack = 1'b1; mem_rdata = rdat; rd_en = 1'b0; wr_en = 1'b0;
                end
                breq++;
            end else begin
                rd_en = 1'b0; wr_en = 1'b0;
            end
        end
        obs_nreq = breq;
        rd_en = poke; wr_en = 1'b0; mem_ack = 1'b0;
    endtask

    // Compare recorded behaviour against the reference rules.
    task automatic expect_access(input string nm, input logic wr, input logic [31:0] a,
                                 input logic [1:0] sz, input logic uns, input logic [31:0] wd,
                                 input logic [31:0] rdat, input int dly);
        logic mis;
        int   e_nreq, e_lat;
        logic e_err;
        mis = (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0);
        if (mis) begin
            e_nreq = 0; e_lat = 1; e_err = 1'b1;
        end else if (dly < TO) begin
            e_nreq = dly + 1; e_lat = dly + 2; e_err = 1'b0;
            if (!wr) ld_model = ref_load(rdat, a[1:0], sz, uns);
        end else begin
            e_nreq = TO; e_lat = TO + 1; e_err = 1'b1;
        end
        check({nm, " done_seen"}, 32'(obs_done), 32'd1);
        check({nm, " latency"}, obs_lat, e_lat);
        check({nm, " req_cycles"}, obs_nreq, e_nreq);
        check({nm, " err"}, 32'(obs_err), 32'(e_err));
        check({nm, " load_data"}, obs_load, ld_model);
        check({nm, " be_in_done"}, 32'(obs_be_done), 32'd0);
        check({nm, " req_in_done"}, 32'(obs_req_done), 32'd0);
        if (!mis) begin
            check({nm, " mem_addr"}, obs_addr, a & 32'hFFFF_FFFC);
            check({nm, " mem_be"}, 32'(obs_be), 32'(ref_be(a[1:0], sz)));
            check({nm, " mem_wdata"}, obs_wdata, ref_wdata(wd, sz));
            check({nm, " mem_we"}, 32'(obs_we), 32'(wr));
            check({nm, " stable"}, 32'(obs_stable), 32'd1);
        end
    endtask

    initial begin
        rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; addr = '0; mem_write = '0;
        size = '0; ld_unsigned = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
        ld_model = '0;

        //          rd  wr  addr          sz     uns wdata         rdata         dly e_addr        e_be     e_wdata       we  e_load        err lat nreq
        vecs[0]  = '{0, 1, 32'h0000_0100, 2'b10, 0, 32'hDEAD_BEEF, 32'h0,        0, 32'h0000_0100, 4'b1111, 32'hDEAD_BEEF, 1, 32'h0000_0000, 0, 2, 1};
        vecs[1]  = '{1, 0, 32'h0000_0103, 2'b00, 0, 32'h0,        32'h8012_3456, 0, 32'h0000_0100, 4'b1000, 32'h0,         0, 32'hFFFF_FF80, 0, 2, 1};
        vecs[2]  = '{1, 0, 32'h0000_0103, 2'b00, 1, 32'h0,        32'h8012_3456, 0, 32'h0000_0100, 4'b1000, 32'h0,         0, 32'h0000_0080, 0, 2, 1};
        vecs[3]  = '{1, 0, 32'h0000_0201, 2'b01, 0, 32'h0,        32'h0,         0, 32'h0,         4'b0000, 32'h0,         0, 32'h0000_0080, 1, 1, 0};
        vecs[4]  = '{1, 0, 32'h0000_0302, 2'b01, 0, 32'h0,        32'hABCD_1234, 2, 32'h0000_0300, 4'b1100, 32'h0,         0, 32'hFFFF_ABCD, 0, 4, 3};
        vecs[5]  = '{1, 1, 32'h0000_0041, 2'b00, 0, 32'h0000_00A5, 32'h0,        1, 32'h0000_0040, 4'b0010, 32'hA5A5_A5A5, 1, 32'hFFFF_ABCD, 0, 3, 2};
        vecs[6]  = '{0, 1, 32'h0000_0052, 2'b01, 0, 32'h1234_BEEF, 32'h0,        3, 32'h0000_0050, 4'b1100, 32'hBEEF_BEEF, 1, 32'hFFFF_ABCD, 0, 5, 4};
        vecs[7]  = '{1, 0, 32'h0000_0060, 2'b10, 0, 32'h0,        32'hCAFE_F00D, 9, 32'h0000_0060, 4'b1111, 32'h0,         0, 32'hFFFF_ABCD, 1, 5, 4};
        vecs[8]  = '{1, 0, 32'h0000_0070, 2'b11, 0, 32'h0,        32'h0,         0, 32'h0,         4'b0000, 32'h0,         0, 32'hFFFF_ABCD, 1, 1, 0};
        vecs[9]  = '{1, 0, 32'h0000_0080, 2'b10, 0, 32'h0,        32'h1357_9BDF, 0, 32'h0000_0080, 4'b1111, 32'h0,         0, 32'h1357_9BDF, 0, 2, 1};
        vecs[10] = '{0, 1, 32'h0000_0082, 2'b10, 0, 32'h5555_5555, 32'h0,        0, 32'h0,         4'b0000, 32'h0,         0, 32'h1357_9BDF, 1, 1, 0};
        vecs[11] = '{1, 0, 32'h0000_0090, 2'b01, 1, 32'h0,        32'h1234_F00F, 0, 32'h0000_0090, 4'b0011, 32'h0,         0, 32'h0000_F00F, 0, 2, 1};

        // Reset values.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst busy", 32'(busy), 0);
        check("rst done", 32'(done), 0);
        check("rst err", 32'(err), 0);
        check("rst mem_req", 32'(mem_req), 0);
        check("rst mem_we", 32'(mem_we), 0);
        check("rst mem_be", 32'(mem_be), 0);
        check("rst mem_addr", mem_addr, 0);
        check("rst mem_wdata", mem_wdata, 0);
        check("rst load_data", load_data, 0);
        rst = 1'b0;

        // Directed vector table.
        for (int i = 0; i < 12; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            run_access(vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].sz, vecs[i].uns,
                       vecs[i].wd, vecs[i].rdat, vecs[i].dly, 1'b0);
            check({nm, " done_seen"}, 32'(obs_done), 1);
            check({nm, " latency"}, obs_lat, vecs[i].e_lat);
            check({nm, " req_cycles"}, obs_nreq, vecs[i].e_nreq);
            check({nm, " err"}, 32'(obs_err), 32'(vecs[i].e_err));
            check({nm, " load_data"}, obs_load, vecs[i].e_load);
            check({nm, " mem_addr"}, obs_addr, vecs[i].e_addr);
            check({nm, " mem_be"}, 32'(obs_be), 32'(vecs[i].e_be));
            check({nm, " mem_wdata"}, obs_wdata, vecs[i].e_wdata);
            check({nm, " mem_we"}, 32'(obs_we), 32'(vecs[i].e_we));
            check({nm, " stable"}, 32'(obs_stable), 1);
            ld_model = vecs[i].e_load;
        end

        // Timeout followed by a stray ack two cycles later.
        run_access(1'b1, 1'b0, 32'h0000_0200, 2'b10, 1'b0, 32'h0, 32'h0, 99, 1'b0);
        expect_access("timeout", 1'b0, 32'h0000_0200, 2'b10, 1'b0, 32'h0, 32'h0, 99);
        @(negedge clk);
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            mem_ack = 1'b0;
            check("stray_ack busy", 32'(busy), 0);
            check("stray_ack done", 32'(done), 0);
            check("stray_ack mem_req", 32'(mem_req), 0);
            check("stray_ack load_data", load_data, ld_model);
        end

        // Request held during DONE is ignored.
        run_access(1'b0, 1'b1, 32'h0000_0300, 2'b10, 1'b0, 32'h1111_2222, 32'h0, 0, 1'b1);
        expect_access("done_poke", 1'b1, 32'h0000_0300, 2'b10, 1'b0, 32'h1111_2222, 32'h0, 0);
        @(negedge clk);
        check("done_poke busy", 32'(busy), 0);
        rd_en = 1'b0;

        // Reset in the second busy cycle abandons the access.
        @(negedge clk);
        rd_en = 1'b1; addr = 32'h0000_0104; size = 2'b10; ld_unsigned = 1'b0; mem_ack = 1'b0;
        @(negedge clk);
        rd_en = 1'b0;
        @(negedge clk);
        check("midrst req_before", 32'(mem_req), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst mem_req", 32'(mem_req), 0);
        check("midrst busy", 32'(busy), 0);
        check("midrst done", 32'(done), 0);
        check("midrst err", 32'(err), 0);
        check("midrst mem_be", 32'(mem_be), 0);
        check("midrst mem_we", 32'(mem_we), 0);
        check("midrst mem_addr", mem_addr, 0);
        check("midrst mem_wdata", mem_wdata, 0);
        check("midrst load_data", load_data, 0);
        ld_model = '0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("midrst no_done", 32'(done), 0);
        end
        run_access(1'b1, 1'b0, 32'h0000_0104, 2'b01, 1'b0, 32'h0, 32'h7FFF_8001, 1, 1'b0);
        expect_access("after_rst", 1'b0, 32'h0000_0104, 2'b01, 1'b0, 32'h0, 32'h7FFF_8001, 1);

        // Randomized accesses.
        for (int i = 0; i < 60; i++) begin
            logic        r_rd, r_wr, r_uns;
            logic [31:0] r_a, r_wd, r_rdat;
            logic [1:0]  r_sz;
            int          r_dly;
            r_wr = 1'($urandom_range(0, 1));
            r_rd = r_wr ? 1'($urandom_range(0, 1)) : 1'b1;
            r_a = $urandom; r_wd = $urandom; r_rdat = $urandom;
            r_sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            if ($urandom_range(0, 3) != 0) begin
                if (r_sz == 2'd2) r_a[1:0] = 2'b00;
                if (r_sz == 2'd1) r_a[0] = 1'b0;
            end
            r_uns = 1'($urandom_range(0, 1));
            r_dly = $urandom_range(0, TO + 1);
            run_access(r_rd, r_wr, r_a, r_sz, r_uns, r_wd, r_rdat, r_dly, 1'b0);
            expect_access($sformatf("rand%0d", i), r_wr, r_a, r_sz, r_uns, r_wd, r_rdat, r_dly);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d",
                 n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL use parameter TIMEOUT_CYCLES, default 255: the number of BUSY cycles without mem_ack before the access is aborted.
REQ-002 The block SHALL have port clk, in, 1: the single clock.
REQ-003 The block SHALL have port rst, in, 1: reset; one clock, and reset is synchronous and active-high.
REQ-004 The block SHALL have port rd_en, in, 1: load request from the control unit.
REQ-005 The block SHALL have port wr_en, in, 1: store request from the control unit.
REQ-006 The block SHALL have port addr, in, 32: byte address of the access.
REQ-007 The block SHALL have port mem_write, in, 32: store data, right-aligned.
REQ-008 The block SHALL have port size, in, 2: access size; 00 byte, 01 half, 10 word, 11 reserved.
REQ-009 The block SHALL have port ld_unsigned, in, 1: zero-extend the load when set.
REQ-010 The block SHALL have the following outputs: busy (1, access in flight); done (1, one-cycle completion pulse); err (1, one-cycle pulse, qualified by done); load_data (32, extended load result).
REQ-011 The block SHALL have the following memory-side outputs: mem_req (1); mem_we (1); mem_addr (32, word-aligned); mem_wdata (32); mem_be (4, byte enables).
REQ-012 The block SHALL have memory-side inputs mem_ack (1) and mem_rdata (32).

Function
REQ-013 FSM states SHALL be IDLE, BUSY and DONE.
REQ-014 In IDLE, a request SHALL be accepted on any cycle where rd_en or wr_en is high; if both are high, wr_en SHALL win.
REQ-015 On acceptance, addr, size, ld_unsigned, direction and steered store data SHALL be latched; later input changes SHALL NOT affect the access.
REQ-016 Misaligned requests SHALL skip memory and go straight to DONE with err=1: size=01 with addr[0]=1; size=10 with addr[1:0]!=0; or size=11.
REQ-017 An aligned request SHALL go to BUSY.
REQ-018 In BUSY, mem_req SHALL be 1, and mem_addr, mem_we, mem_be and mem_wdata SHALL stay stable until the cycle mem_ack is sampled high.
REQ-019 mem_addr SHALL equal {addr[31:2],2'b00}.
REQ-020 mem_be SHALL be 0001<<addr[1:0] for a byte, 0011<<addr[1:0] for a half, and 1111 for a word; mem_be SHALL be 0000 outside BUSY.
REQ-021 mem_wdata SHALL be {4{d[7:0]}} for a byte, {2{d[15:0]}} for a half, and d for a word.
REQ-022 When mem_ack is high in BUSY, the next state SHALL be DONE; for a load, load_data SHALL capture mem_rdata shifted right by 8*addr[1:0], then sign- or zero-extended to 32 bits per size and ld_unsigned.
REQ-023 Minimum latency SHALL be 2 cycles, request-accept edge to done, with ack in the first BUSY cycle.
REQ-024 A BUSY-cycle counter SHALL run; on reaching TIMEOUT_CYCLES with no ack, the next state SHALL be DONE with err=1, mem_req SHALL drop, and load_data SHALL be unchanged.
REQ-025 An ack on the timeout cycle SHALL win over the timeout, completing normally.
REQ-026 DONE SHALL last exactly one cycle, with done=1, then return to IDLE; requests presented in DONE SHALL be ignored.
REQ-027 busy SHALL be 1 in BUSY and DONE; rd_en and wr_en SHALL be ignored while busy=1.
REQ-028 mem_ack outside BUSY SHALL be ignored.
REQ-029 load_data SHALL hold its value until the next successful load completes.
REQ-030 Stores SHALL NOT modify load_data.

Reset
REQ-031 While rst is high at a clk edge, the state SHALL go to IDLE, the counter SHALL clear, and these outputs SHALL be 0: busy, done, err, mem_req, mem_we, mem_be, mem_addr, mem_wdata, load_data.
REQ-032 If rst arrives in BUSY, the access SHALL be abandoned with no done pulse; mem_req SHALL be 0 from the following cycle.

Structure
REQ-033 Package lsu_pkg SHALL hold the size encodings (SZ_B, SZ_H, SZ_W), the FSM state type, and the default timeout.
REQ-034 Byte-lane steering SHALL live in a combinational sub-module, lsu_align. It covers store replication, mem_be generation, load extract/extend and the misalignment check.
REQ-035 The FSM and counter SHALL live in load_store_unit.

Verification
REQ-036 Word store: wr_en, addr=0x100, size=10, mem_write=0xDEADBEEF, ack on the first BUSY cycle -> mem_addr=0x100, mem_be=1111, mem_wdata=0xDEADBEEF, mem_we=1, done 2 cycles after accept, err=0.
REQ-037 Signed byte load: rd_en, addr=0x103, size=00, ld_unsigned=0, mem_rdata=0x80123456 -> mem_be=1000, load_data=0xFFFFFF80; repeat with ld_unsigned=1 -> load_data=0x00000080.
REQ-038 Misaligned half: rd_en, addr=0x201, size=01 -> mem_req never asserted, done=1 and err=1 one cycle after accept, load_data unchanged.
REQ-039 Timeout: TIMEOUT_CYCLES=4, load with mem_ack held 0 -> mem_req high for 4 cycles, then done=1 and err=1; a stray ack two cycles later is ignored.
REQ-040 Stall and collision: ack delayed 3 cycles while rd_en, wr_en and addr toggle in BUSY -> memory outputs stable, no second access; rd_en and wr_en both high in IDLE -> store performed.
REQ-041 Reset mid-access: rst pulsed in the 2nd BUSY cycle -> mem_req=0 the next cycle, no done, all outputs 0, and the next request completes normally.
